// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter feeding a one-deep command stage into a set/reset flag bank.
// Illegal commands (s=r=1 or out-of-range index) leave the bank untouched and bump err_cnt.
module sr_flag_arbiter #(
  parameter int NREQ = 4,
  parameter int NFLAG = 8,
  parameter int IDXW = 3,
  parameter logic [NFLAG-1:0] RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_s,
  input  logic [NREQ-1:0]      req_r,
  input  logic [NREQ*IDXW-1:0] req_idx,
  output logic [NREQ-1:0]      req_ready,
  output logic [NFLAG-1:0]     flags,
  output logic                 upd_valid,
  output logic [2:0]           upd_src,
  output logic                 err_pulse,
  output logic [7:0]           err_cnt
);

  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic            stg_v_q, stg_v_d;
  logic            stg_s_q, stg_s_d;
  logic            stg_r_q, stg_r_d;
  logic [IDXW-1:0] stg_idx_q, stg_idx_d;
  logic [2:0]      stg_src_q, stg_src_d;
  logic [NFLAG-1:0] flags_q, flags_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [NREQ-1:0] grant;
  logic            gany;
  logic            illegal;

  // Search starts at rr_ptr and wraps; the first valid requester wins.
  always_comb begin
    grant     = '0;
    gany      = 1'b0;
    stg_v_d   = 1'b0;
    stg_s_d   = stg_s_q;
    stg_r_d   = stg_r_q;
    stg_idx_d = stg_idx_q;
    stg_src_d = stg_src_q;
    rr_ptr_d  = rr_ptr_q;
    if (rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        for (int j = 0; j < NREQ; j++) begin
          if (!gany && req_valid[j] &&
              j == (int'(rr_ptr_q) + k) % NREQ) begin
            grant[j]  = 1'b1;
            gany      = 1'b1;
            stg_v_d   = 1'b1;
            stg_s_d   = req_s[j];
            stg_r_d   = req_r[j];
            stg_idx_d = req_idx[j*IDXW +: IDXW];
            stg_src_d = 3'(j);
            rr_ptr_d  = 3'((j + 1) % NREQ);
          end
        end
      end
    end
  end

  assign illegal = (stg_s_q & stg_r_q) |
                   (int'(stg_idx_q) >= NFLAG);

  always_comb begin
    flags_d   = flags_q;
    err_cnt_d = err_cnt_q;
    if (stg_v_q) begin
      if (illegal) begin
        if (err_cnt_q != 8'hFF)
          err_cnt_d = err_cnt_q + 8'd1;
      end else if (stg_s_q ^ stg_r_q) begin
        for (int f = 0; f < NFLAG; f++) begin
          if (int'(stg_idx_q) == f)
            flags_d[f] = stg_s_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      stg_v_q   <= 1'b0;
      stg_s_q   <= 1'b0;
      stg_r_q   <= 1'b0;
      stg_idx_q <= '0;
      stg_src_q <= '0;
      flags_q   <= RST_VAL;
      err_cnt_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      stg_v_q   <= stg_v_d;
      stg_s_q   <= stg_s_d;
      stg_r_q   <= stg_r_d;
      stg_idx_q <= stg_idx_d;
      stg_src_q <= stg_src_d;
      flags_q   <= flags_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign req_ready = grant;
  assign flags     = flags_q;
  assign upd_valid = stg_v_q;
  assign upd_src   = stg_src_q;
  assign err_pulse = stg_v_q & illegal;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed and random bench for sr_flag_arbiter against a behavioural model.
// IDXW=4 so that indices beyond the 8-flag bank can be exercised.
module tb_sr_flag_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_s, req_r;
  logic [15:0] req_idx;
  logic [3:0]  req_ready;
  logic [7:0]  flags;
  logic        upd_valid;
  logic [2:0]  upd_src;
  logic        err_pulse;
  logic [7:0]  err_cnt;

  int n_chk = 0;
  int n_fail = 0;

  int       m_ptr, m_cnt, m_last_g;
  bit [7:0] m_flags;
  bit       m_sv, m_ss, m_sr;
  int       m_sidx, m_ssrc;

  sr_flag_arbiter #(
    .NREQ(4), .NFLAG(8), .IDXW(4), .RST_VAL(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_s(req_s),
    .req_r(req_r), .req_idx(req_idx),
    .req_ready(req_ready), .flags(flags),
    .upd_valid(upd_valid), .upd_src(upd_src),
    .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic int m_grant();
    if (!rst_n) return -1;
    for (int k = 0; k < 4; k++)
      if (req_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] m_ready();
    int g = m_grant();
    logic [3:0] v = 4'b0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic bit m_err();
    return m_sv && ((m_ss && m_sr) || m_sidx >= 8);
  endfunction

  // Model advances on the same edge as the DUT; inputs change 1ns later.
  task automatic adv();
    int g;
    @(posedge clk);
    if (!rst_n) begin
      m_flags = 8'h00; m_ptr = 0; m_sv = 0;
      m_cnt = 0; m_last_g = -1;
    end else begin
      if (m_sv) begin
        if (m_err()) begin
          if (m_cnt < 255) m_cnt++;
        end else if (m_ss && !m_sr) m_flags[m_sidx] = 1'b1;
        else if (m_sr && !m_ss) m_flags[m_sidx] = 1'b0;
      end
      g = m_grant();
      m_last_g = g;
      m_sv = (g >= 0);
      if (m_sv) begin
        m_ss = req_s[g];
        m_sr = req_r[g];
        m_sidx = int'(req_idx[g*4 +: 4]);
        m_ssrc = g;
        m_ptr = (g + 1) % 4;
      end
    end
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input bit s,
                         input bit r, input int idx);
    req_valid[i] = v;
    req_s[i] = s;
    req_r[i] = r;
    req_idx[i*4 +: 4] = 4'(idx);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    req_valid = '0;
    adv();
    adv();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'hF; req_s = '0; req_r = '0; req_idx = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_chk++;
      if (req_ready !== 4'b0) begin
        n_fail++;
        $display("FAIL reset_ready got=%b exp=0000", req_ready);
      end
      adv();
    end
    rst_n = 1'b1;
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++;
      if (flags !== 8'h00 || err_cnt !== 8'd0 || upd_valid !== 1'b0 ||
          err_pulse !== 1'b0 || req_ready !== 4'b0) begin
        n_fail++;
        $display("FAIL reset_state flags=%h cnt=%0d uv=%b ep=%b rdy=%b exp 00/0/0/0/0000",
                 flags, err_cnt, upd_valid, err_pulse, req_ready);
      end
      adv();
    end
  endtask

  task automatic test_single();
    reset_dut();
    set_req(0, 1, 1, 0, 5);
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_ready got=%b exp=0001", req_ready);
    end
    adv();
    req_valid = '0;
    @(negedge clk);
    n_chk++;
    if (upd_valid !== 1'b1 || upd_src !== 3'd0) begin
      n_fail++;
      $display("FAIL single_stage uv=%b src=%0d exp 1/0", upd_valid, upd_src);
    end
    adv();
    @(negedge clk);
    n_chk++;
    if (flags !== 8'h20) begin
      n_fail++;
      $display("FAIL single_flags got=%h exp=20", flags);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_a [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_b [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0100};
    reset_dut();
    for (int i = 0; i < 4; i++) set_req(i, 1, 0, 0, i);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++;
      if (req_ready !== exp_a[c]) begin
        n_fail++;
        $display("FAIL rr_all step=%0d got=%b exp=%b", c, req_ready, exp_a[c]);
      end
      adv();
    end
    req_valid[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++;
      if (req_ready !== exp_b[c]) begin
        n_fail++;
        $display("FAIL rr_skip step=%0d got=%b exp=%b", c, req_ready, exp_b[c]);
      end
      adv();
    end
    req_valid = '0;
  endtask

  task automatic test_illegal();
    reset_dut();
    set_req(0, 1, 1, 0, 2);
    adv();
    req_valid = '0;
    adv();
    @(negedge clk);
    n_chk++;
    if (flags !== 8'h04) begin
      n_fail++;
      $display("FAIL ill_setup flags=%h exp=04", flags);
    end
    set_req(0, 1, 1, 1, 2);
    adv();
    req_valid = '0;
    @(negedge clk);
    n_chk++;
    if (err_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_pulse got=%b exp=1", err_pulse);
    end
    adv();
    @(negedge clk);
    n_chk++;
    if (flags !== 8'h04 || err_cnt !== 8'd1 || err_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL ill_11 flags=%h cnt=%0d ep=%b exp 04/1/0", flags, err_cnt, err_pulse);
    end
    set_req(0, 1, 1, 0, 9);
    adv();
    req_valid = '0;
    @(negedge clk);
    n_chk++;
    if (err_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_idx_pulse got=%b exp=1", err_pulse);
    end
    adv();
    @(negedge clk);
    n_chk++;
    if (flags !== 8'h04 || err_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL ill_idx flags=%h cnt=%0d exp 04/2", flags, err_cnt);
    end
    set_req(0, 1, 1, 1, 2);
    for (int c = 0; c < 300; c++) adv();
    req_valid = '0;
    adv();
    adv();
    @(negedge clk);
    n_chk++;
    if (err_cnt !== 8'd255 || flags !== 8'h04) begin
      n_fail++;
      $display("FAIL ill_sat cnt=%0d flags=%h exp 255/04", err_cnt, flags);
    end
  endtask

  task automatic test_contention();
    reset_dut();
    set_req(1, 1, 0, 0, 0);
    adv();
    req_valid = '0;
    set_req(2, 1, 1, 0, 3);
    set_req(3, 1, 0, 1, 3);
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL cont_first got=%b exp=0100", req_ready);
    end
    adv();
    req_valid[2] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL cont_second got=%b exp=1000", req_ready);
    end
    adv();
    req_valid = '0;
    @(negedge clk);
    n_chk++;
    if (flags[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL cont_mid flag3=%b exp=1", flags[3]);
    end
    adv();
    @(negedge clk);
    n_chk++;
    if (flags !== 8'h00) begin
      n_fail++;
      $display("FAIL cont_final flags=%h exp=00", flags);
    end
  endtask

  task automatic test_reset_midop();
    reset_dut();
    set_req(1, 1, 1, 0, 6);
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL mid_grant got=%b exp=0010", req_ready);
    end
    adv();
    rst_n = 1'b0;
    req_valid = 4'hF;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0) begin
      n_fail++;
      $display("FAIL mid_rst_ready got=%b exp=0000", req_ready);
    end
    adv();
    rst_n = 1'b1;
    req_valid = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_chk++;
      if (flags !== 8'h00 || upd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_drop flags=%h uv=%b exp 00/0", flags, upd_valid);
      end
      adv();
    end
    req_valid = 4'hF;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_ptr got=%b exp=0001", req_ready);
    end
    req_valid = '0;
    adv();
  endtask

  task automatic test_random();
    logic [3:0] er;
    reset_dut();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++)
        if (!(req_valid[i] && m_last_g != i))
          set_req(i, $urandom_range(0, 2) != 0, 1'($urandom),
                  1'($urandom), int'($urandom_range(0, 9)));
      @(negedge clk);
      er = m_ready();
      n_chk++;
      if (req_ready !== er || upd_valid !== m_sv ||
          (m_sv && upd_src !== 3'(m_ssrc)) ||
          err_pulse !== m_err() || flags !== m_flags ||
          err_cnt !== 8'(m_cnt)) begin
        n_fail++;
        $display("FAIL rand c=%0d rdy=%b/%b uv=%b/%b src=%0d/%0d ep=%b/%b fl=%h/%h cnt=%0d/%0d",
                 c, req_ready, er, upd_valid, m_sv, upd_src, m_ssrc,
                 err_pulse, m_err(), flags, m_flags, err_cnt, m_cnt);
      end
      adv();
    end
    req_valid = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_s = '0; req_r = '0; req_idx = '0;
    m_ptr = 0; m_cnt = 0; m_last_g = -1; m_flags = 8'h00;
    m_sv = 0; m_ss = 0; m_sr = 0; m_sidx = 0; m_ssrc = 0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_illegal();
    test_contention();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
